// File: rtl/mem_arbiter.sv
// Two-requester (CPU / program loader) arbiter for a single-port synchronous memory.
// Define MEM_ARB_LOADER_PRIORITY_EN for fixed loader priority; default is round-robin.
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_write,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ldr_req,
   input  logic          ldr_write,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_ack,
   output logic [DW-1:0] ldr_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t        state, state_nxt;
   logic          owner;      // 0 = cpu, 1 = loader
   logic          write_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          grant;
   logic          grant_ldr;
   logic          resp_ack;

   assign grant = (state == IDLE) && (cpu_req || ldr_req);

`ifdef MEM_ARB_LOADER_PRIORITY_EN
   assign grant_ldr = ldr_req;
`else
   logic last_grant;          // 0 = cpu, 1 = loader; reset to loader so the cpu wins the first tie

   assign grant_ldr = ldr_req && (!cpu_req || !last_grant);

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (grant)
         last_grant <= grant_ldr;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Winner's request is captured once; requester inputs are don't-care until IDLE again.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant) begin
         owner   <= grant_ldr;
         write_q <= grant_ldr ? ldr_write : cpu_write;
         addr_q  <= grant_ldr ? ldr_addr  : cpu_addr;
         wdata_q <= grant_ldr ? ldr_wdata : cpu_wdata;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      resp_ack  = 1'b0;
      case (state)
         IDLE:    if (cpu_req || ldr_req) state_nxt = ISSUE;
         ISSUE: begin
            mem_we    = write_q && !rst;
            state_nxt = RESP;
         end
         RESP: begin
            resp_ack  = !rst;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latched registers double as the memory bus, so the bus holds its last value when idle.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != IDLE);

   // A reset landing in RESP suppresses the ack so an aborted access never completes.
   assign cpu_ack   = resp_ack && !owner;
   assign ldr_ack   = resp_ack &&  owner;
   assign cpu_rdata = (cpu_ack && !write_q) ? mem_rdata : '0;
   assign ldr_rdata = (ldr_ack && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
// Expectations follow MEM_ARB_LOADER_PRIORITY_EN when it is defined for the build.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_write, ldr_req, ldr_write;
   logic [7:0]  cpu_addr, ldr_addr, mem_addr;
   logic [31:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata, cpu_rdata, ldr_rdata;
   logic        cpu_ack, ldr_ack, mem_we, busy;
   logic        mem_init;

   logic [31:0] tmem [256];
   logic [31:0] refm [256];

   int nerr = 0;
   int nchk = 0;

   // transaction-level model state
   int          free_at, ack_at;
   logic        own, lg, ewr;
   logic [7:0]  eaddr;
   logic [31:0] ewd, erd;
   logic        prio;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(8), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_write(ldr_write), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   function automatic logic [31:0] pat(int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
   endfunction

   // synchronous single-port memory
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) tmem[i] <= pat(i);
      end else if (mem_we) begin
         tmem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= tmem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic rnd_cpu();
      cpu_write = 1'($urandom_range(0, 1));
      cpu_addr  = 8'($urandom);
      cpu_wdata = $urandom;
   endtask

   task automatic rnd_ldr();
      ldr_write = 1'($urandom_range(0, 1));
      ldr_addr  = 8'($urandom);
      ldr_wdata = $urandom;
   endtask

   initial begin
`ifdef MEM_ARB_LOADER_PRIORITY_EN
      prio = 1'b1;
`else
      prio = 1'b0;
`endif
      for (int i = 0; i < 256; i++) refm[i] = pat(i);
      rst = 1'b1; mem_init = 1'b1;
      cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
      ldr_req = 0; ldr_write = 0; ldr_addr = 0; ldr_wdata = 0;

      // reset state
      step();
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cack", 32'(cpu_ack), 0);
      chk("rst_lack", 32'(ldr_ack), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_crd", cpu_rdata, 0);
      chk("rst_lrd", ldr_rdata, 0);
      step();

      // cpu write 0x10
      rst = 1'b0;
      cpu_req = 1; cpu_write = 1; cpu_addr = 8'h10; cpu_wdata = 32'hDEAD_BEEF;
      @(negedge clk); chk("wr_c1_busy", 32'(busy), 0); chk("wr_c1_we", 32'(mem_we), 0);
      step();
      @(negedge clk);
      chk("wr_c2_we", 32'(mem_we), 1);
      chk("wr_c2_addr", 32'(mem_addr), 32'h10);
      chk("wr_c2_wd", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_c2_busy", 32'(busy), 1);
      step();
      @(negedge clk);
      chk("wr_c3_cack", 32'(cpu_ack), 1);
      chk("wr_c3_crd", cpu_rdata, 0);
      chk("wr_c3_lack", 32'(ldr_ack), 0);
      chk("wr_c3_we", 32'(mem_we), 0);
      refm[8'h10] = 32'hDEAD_BEEF;
      step();
      cpu_req = 0;
      @(negedge clk);
      chk("wr_c4_cack", 32'(cpu_ack), 0);
      chk("wr_c4_busy", 32'(busy), 0);
      chk("wr_c4_hold", 32'(mem_addr), 32'h10);
      step();

      // cpu read 0x10
      cpu_req = 1; cpu_write = 0; cpu_addr = 8'h10; cpu_wdata = 32'h0;
      @(negedge clk); chk("rd_c1_we", 32'(mem_we), 0);
      step();
      @(negedge clk); chk("rd_c2_we", 32'(mem_we), 0); chk("rd_c2_addr", 32'(mem_addr), 32'h10);
      step();
      @(negedge clk);
      chk("rd_c3_cack", 32'(cpu_ack), 1);
      chk("rd_c3_crd", cpu_rdata, 32'hDEAD_BEEF);
      chk("rd_c3_we", 32'(mem_we), 0);
      step();
      cpu_req = 0;

      // continuous contention from reset
      do_reset();
      cpu_req = 1; cpu_write = 0; cpu_addr = 8'h01;
      ldr_req = 1; ldr_write = 0; ldr_addr = 8'h02;
      for (int c = 1; c <= 12; c++) begin
         logic ec, el;
         @(negedge clk);
         ec = !prio && (c % 3 == 0) && ((c / 3) % 2 == 1);
         el = (c % 3 == 0) && !ec;
         chk($sformatf("cont_cack_%0d", c), 32'(cpu_ack), 32'(ec));
         chk($sformatf("cont_lack_%0d", c), 32'(ldr_ack), 32'(el));
         chk($sformatf("cont_crd_%0d", c), cpu_rdata, ec ? refm[1] : 32'h0);
         chk($sformatf("cont_lrd_%0d", c), ldr_rdata, el ? refm[2] : 32'h0);
         step();
      end
      cpu_req = 0; ldr_req = 0;

      // loader write aborted by reset in ISSUE
      do_reset();
      ldr_req = 1; ldr_write = 1; ldr_addr = 8'hFF; ldr_wdata = 32'h1234_5678;
      @(negedge clk); chk("ab_c1_busy", 32'(busy), 0);
      step();
      rst = 1'b1;
      @(negedge clk); chk("ab_c2_we", 32'(mem_we), 0); chk("ab_c2_lack", 32'(ldr_ack), 0);
      step();
      rst = 1'b0; ldr_req = 0;
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("ab_c%0d_busy", c), 32'(busy), 0);
         chk($sformatf("ab_c%0d_lack", c), 32'(ldr_ack), 0);
         step();
      end
      chk("ab_mem_ff", tmem[8'hFF], refm[8'hFF]);

      // cpu pulse during loader RESP
      ldr_req = 1; ldr_write = 0; ldr_addr = 8'h05;
      step(); step();
      cpu_req = 1; cpu_write = 1; cpu_addr = 8'h44; cpu_wdata = 32'h5555_5555;
      @(negedge clk);
      chk("pl_lack", 32'(ldr_ack), 1);
      chk("pl_lrd", ldr_rdata, refm[5]);
      chk("pl_cack", 32'(cpu_ack), 0);
      step();
      cpu_req = 0; ldr_req = 0;
      for (int c = 4; c <= 7; c++) begin
         @(negedge clk);
         chk($sformatf("pl_c%0d_cack", c), 32'(cpu_ack), 0);
         chk($sformatf("pl_c%0d_busy", c), 32'(busy), 0);
         chk($sformatf("pl_c%0d_we", c), 32'(mem_we), 0);
         step();
      end

      // loader arrives as cpu is granted; cpu address changes mid-access
      cpu_req = 1; cpu_write = 0; cpu_addr = 8'h20;
      step();
      ldr_req = 1; ldr_write = 0; ldr_addr = 8'h30; cpu_addr = 8'h33;
      @(negedge clk); chk("la_c2_addr", 32'(mem_addr), 32'h20);
      step();
      @(negedge clk);
      chk("la_c3_cack", 32'(cpu_ack), 1);
      chk("la_c3_crd", cpu_rdata, refm[8'h20]);
      chk("la_c3_addr", 32'(mem_addr), 32'h20);
      step();
      cpu_req = 0;
      @(negedge clk); chk("la_c4_busy", 32'(busy), 0);
      step();
      @(negedge clk); chk("la_c5_addr", 32'(mem_addr), 32'h30); chk("la_c5_busy", 32'(busy), 1);
      step();
      @(negedge clk); chk("la_c6_lack", 32'(ldr_ack), 1); chk("la_c6_lrd", ldr_rdata, refm[8'h30]);
      step();
      ldr_req = 0;

      // randomized traffic against the transaction model
      do_reset();
      lg = 1'b1; own = 1'b0; free_at = 0; ack_at = -1;
      ewr = 0; eaddr = 0; ewd = 0; erd = 0;
      for (int k = 0; k < 400; k++) begin
         logic ec, el;
         @(negedge clk);
         ec = (k == ack_at) && !own;
         el = (k == ack_at) &&  own;
         chk("rnd_cack", 32'(cpu_ack), 32'(ec));
         chk("rnd_lack", 32'(ldr_ack), 32'(el));
         chk("rnd_crd", cpu_rdata, (ec && !ewr) ? erd : 32'h0);
         chk("rnd_lrd", ldr_rdata, (el && !ewr) ? erd : 32'h0);
         chk("rnd_busy", 32'(busy), 32'(k < free_at));
         chk("rnd_we", 32'(mem_we), 32'((k == ack_at - 1) && ewr));
         if (k == ack_at - 1) begin
            chk("rnd_addr", 32'(mem_addr), 32'(eaddr));
            chk("rnd_wd", mem_wdata, ewd);
         end
         if (k >= free_at && (cpu_req || ldr_req)) begin
            if (cpu_req && ldr_req) own = prio ? 1'b1 : !lg;
            else                    own = ldr_req;
            lg    = own;
            ewr   = own ? ldr_write : cpu_write;
            eaddr = own ? ldr_addr  : cpu_addr;
            ewd   = own ? ldr_wdata : cpu_wdata;
            erd   = refm[eaddr];
            if (ewr) refm[eaddr] = ewd;
            ack_at  = k + 2;
            free_at = k + 3;
         end
         step();
         if (k == ack_at && !own) begin
            cpu_req = 1'($urandom_range(0, 1));
            if (cpu_req) rnd_cpu();
         end else if (cpu_req && !(k < ack_at && !own)) begin
            if ($urandom_range(0, 7) == 0) cpu_req = 0;
         end else if (!cpu_req && $urandom_range(0, 1) == 1) begin
            cpu_req = 1; rnd_cpu();
         end
         if (k == ack_at && own) begin
            ldr_req = 1'($urandom_range(0, 1));
            if (ldr_req) rnd_ldr();
         end else if (ldr_req && !(k < ack_at && own)) begin
            if ($urandom_range(0, 7) == 0) ldr_req = 0;
         end else if (!ldr_req && $urandom_range(0, 1) == 1) begin
            ldr_req = 1; rnd_ldr();
         end
      end
      cpu_req = 0; ldr_req = 0;
      step();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter AW, default 8, address width in bits.
- REQ-002: Parameter DW, default 32, data width in bits.
- REQ-003: Clock  input  1  single clock; all state updates on rising edge.
- REQ-004: Reset  input  1  synchronous, active-high reset.
- REQ-005: CpuReq  input  1  processor access request; held high until CpuAck.
- REQ-006: CpuWrite  input  1  1 = write, 0 = read; valid while CpuReq is high.
- REQ-007: CpuAddr  input  AW  processor word address.
- REQ-008: CpuWData  input  DW  processor write data.
- REQ-009: CpuAck  output  1  one-cycle completion pulse to the processor.
- REQ-010: CpuRData  output  DW  read data to the processor; valid only while CpuAck is high, 0 otherwise.
- REQ-011: LdrReq, LdrWrite, LdrAddr, LdrWData, LdrAck, LdrRData  same directions, widths and meanings as the Cpu* ports, for the program-loader requester.
- REQ-012: MemAddr  output  AW  address to the single-port memory.
- REQ-013: MemWData  output  DW  write data to the memory.
- REQ-014: MemWE  output  1  memory write enable.
- REQ-015: MemRData  input  DW  memory read data; synchronous, valid one cycle after the address is presented.
- REQ-016: Busy  output  1  high in every state other than IDLE.

Function
- REQ-017: The FSM SHALL have three states: IDLE, ISSUE and RESP.
- REQ-018: Transitions SHALL be: IDLE->ISSUE when CpuReq or LdrReq is high; ISSUE->RESP always; RESP->IDLE always.
- REQ-019: An access SHALL take exactly 3 cycles, from the IDLE sample to the Ack in RESP.
- REQ-020: At the IDLE->ISSUE edge, the winner's Write, Addr and WData SHALL be latched into internal registers, together with a 1-bit Owner register.
- REQ-021: Requester inputs SHALL be ignored after the latch until the next IDLE.
- REQ-022: In ISSUE, MemAddr and MemWData SHALL drive the latched values.
- REQ-023: In ISSUE, MemWE SHALL equal the latched Write bit.
- REQ-024: In every state other than ISSUE, MemWE SHALL be 0; MemAddr and MemWData SHALL hold their last values.
- REQ-025: In RESP, the Owner's Ack SHALL be 1 for exactly one cycle; the other Ack SHALL stay 0.
- REQ-026: For a read, the Owner's RData SHALL equal MemRData during RESP.
- REQ-027: For a write, the Owner's RData SHALL be 0.
- REQ-028: Arbitration SHALL be round-robin using a LastGrant register updated at each grant.
- REQ-029: When both requests are high in IDLE, the requester not named by LastGrant SHALL win.
- REQ-030: When only one request is high, that requester SHALL win regardless of LastGrant.
- REQ-031: A requester keeping Req high through its Ack cycle SHALL be treated as making a new request at the next IDLE.
- REQ-032: A Req that drops before grant SHALL be dropped silently, with no Ack.
- REQ-033: Address handling SHALL wrap naturally at 2^AW, with no range checking.
- REQ-034: Under continuous contention, grants SHALL alternate Cpu, Ldr, Cpu, ...
- REQ-035: Under continuous contention, no requester SHALL wait more than 6 cycles from Req to Ack.

Reset
- REQ-036: On Reset high at a clock edge, the state SHALL be IDLE and Owner SHALL be 0.
- REQ-037: On Reset, LastGrant SHALL be Ldr, so the CPU wins the first tie.
- REQ-038: On Reset, MemAddr, MemWData and the latched registers SHALL be 0.
- REQ-039: On Reset, MemWE, CpuAck, LdrAck and Busy SHALL be 0, and CpuRData and LdrRData SHALL be 0.
- REQ-040: Reset during ISSUE or RESP SHALL abort the access: no Ack SHALL be produced, and MemWE SHALL be 0 from the reset cycle onward.
- REQ-041: The aborted requester SHALL be re-arbitrated normally if it keeps Req high after reset.

Configuration
- REQ-042: Macro MEM_ARB_LOADER_PRIORITY_EN SHALL select the arbitration policy.
- REQ-043: When MEM_ARB_LOADER_PRIORITY_EN is defined, LdrReq SHALL always win ties; LastGrant SHALL be absent or ignored, and the CPU may starve while the loader is active.
- REQ-044: When MEM_ARB_LOADER_PRIORITY_EN is undefined, round-robin per REQ-028..REQ-030 SHALL apply.
- REQ-045: The port list SHALL be identical with and without MEM_ARB_LOADER_PRIORITY_EN.

Verification
- REQ-046: Reset, then hold CpuReq=1, CpuWrite=1, CpuAddr=0x10, CpuWData=0xDEADBEEF -> MemWE=1 with MemAddr=0x10 in cycle 2, and CpuAck=1 with CpuRData=0 in cycle 3.
- REQ-047: Preload memory address 0x10 with 0xDEADBEEF; CpuReq read of 0x10 -> CpuAck=1 with CpuRData=0xDEADBEEF in RESP, and MemWE=0 throughout.
- REQ-048: CpuReq and LdrReq both held high continuously after reset -> Acks in order Cpu, Ldr, Cpu, Ldr, one every 3 cycles; with MEM_ARB_LOADER_PRIORITY_EN defined -> LdrAck only.
- REQ-049: LdrReq write to 0xFF granted, then Reset asserted in ISSUE -> LdrAck never pulses and Busy=0 the cycle after Reset.
- REQ-050: CpuReq pulsed high for 1 cycle while the arbiter is in RESP serving the loader -> no CpuAck and no further memory access.
- REQ-051: LdrReq asserted at the IDLE->ISSUE edge where CpuReq is granted -> loader granted at the next IDLE, and CpuAddr changes during the CPU access do not alter MemAddr.
